mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-outstanding memory bus of mem_ctrl (SPI flash/RAM) between two requesters: CPU (port 0) and debug/loader (port 1).
//  Arbitrates round-robin or fixed-priority and drives the downstream strobes, address and data.
//  Detects completion when bus_wait falls, then returns a one-cycle ack and read data to the winner.
//  Enforces mem_ctrl's recovery: strobes stay low until bus_wait returns high. A watchdog aborts hung transfers.
// PARAMETERS
//  FIXED_PRIO      0    1: port 0 always wins ties; 0: round-robin
//  TIMEOUT_CYCLES  255  max cycles in GRANT before abort; 0 disables the watchdog
//  CNT_W           8    watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1   single clock, all logic posedge
//  rst             in   1   asynchronous, active-high reset
//  cpu_addr        in   16  port 0 address
//  cpu_wdata       in   8   port 0 write data
//  cpu_read        in   1   port 0 read request, level, held until cpu_ack
//  cpu_write       in   1   port 0 write request, level, held until cpu_ack
//  cpu_rdata       out  8   read data, valid while cpu_ack=1
//  cpu_ack         out  1   one-cycle completion pulse
//  cpu_err         out  1   qualifies cpu_ack: transfer timed out
//  dbg_addr/dbg_wdata/dbg_read/dbg_write/dbg_rdata/dbg_ack/dbg_err   same as cpu_*, port 1
//  bus_address     out  16  to mem_ctrl
//  bus_data_tx     out  8   to mem_ctrl
//  bus_read        out  1   to mem_ctrl
//  bus_write       out  1   to mem_ctrl
//  bus_data_rx     in   8   from mem_ctrl; captured when bus_wait=0
//  bus_wait        in   1   from mem_ctrl; 1=busy/idle, 0=data ready
//  grant_id        out  1   port owning the bus; valid while busy=1
//  busy            out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0. State=IDLE, watchdog=0, last_grant=1, so port 0 wins the first tie.
//  Reset mid-transfer drops strobes at once. No ack is issued for the aborted transfer.
//  All outputs registered. States: IDLE, GRANT, RECOVER.
//  IDLE:
//   - A port requests if read|write=1.
//   - If both request: FIXED_PRIO=1 grants port 0; otherwise grant != last_grant.
//   - On grant, next edge: latch addr, wdata and strobe into bus_*; set grant_id and last_grant; go GRANT.
//   - Strobes assert 1 cycle after the request is sampled.
//   - read&write both high on one port: treated as write, bus_read=0.
//  GRANT:
//   - bus_* held constant; requester inputs are ignored after the latch.
//   - Watchdog increments each cycle.
//   - bus_wait sampled 0 and the bus has been driven at least 1 cycle: capture bus_data_rx into winner's rdata, pulse winner's ack for 1 cycle, err=0, strobes to 0, go RECOVER.
//   - Watchdog reaches TIMEOUT_CYCLES first: strobes to 0, rdata=8'hFF, ack=1, err=1, go RECOVER.
//  RECOVER:
//   - Strobes stay 0; watchdog cleared.
//   - Wait for bus_wait=1 (mem_ctrl back in idle), then IDLE.
//   - On the timeout path, if bus_wait is already 1, leave next cycle.
//   - New requests are not granted here.
//  Requester rules:
//   - Requester drops or changes its request in the cycle after ack.
//   - A request still high in IDLE is a new transfer (back-to-back allowed).
//  Loser's request stays pending; it is served next when it still requests.
//  Round-robin: no port waits more than one transfer of the other.
//  rdata holds its last value outside ack; err=0 whenever ack=0.
//  Min transfer = 1 (grant) + mem_ctrl latency + 1 (ack) + RECOVER cycles.
// STRUCTURE
//  Shared package mem_bus_pkg: state encodings ARB_IDLE/ARB_GRANT/ARB_RECOVER, PORT_CPU=0, PORT_DBG=1, ERR_RDATA=8'hFF.
//  One sub-module, arb_rr2 (combinational 2-way round-robin/fixed picker: req[1:0], last, fixed -> gnt).
//  FSM, datapath latch and watchdog stay in mem_bus_arbiter.
// TESTING
//  Mem_ctrl model: bus_wait falls after 40 cycles, stays 0 for 2 cycles, then returns to 1.
//  1 CPU read 0x1234; model returns 0xA5 -> bus_read=1 with addr 0x1234 one cycle later; cpu_ack 1 cycle with rdata=0xA5, err=0; dbg_ack=0.
//  2 Both ports read in the same cycle, FIXED_PRIO=0, held through 4 transfers -> grants 0,1,0,1; no bus_read during RECOVER.
//  3 Same as 2 with FIXED_PRIO=1 and CPU re-requesting immediately -> port 0 always wins; port 1 waits.
//  4 dbg read+write high, addr 0x8001, wdata 0x3C -> bus_write=1, bus_read=0, bus_data_tx=0x3C; dbg_ack on completion.
//  5 TIMEOUT_CYCLES=16, model never lowers bus_wait -> ack at cycle 16 of GRANT with err=1, rdata=0xFF; back in IDLE 1 cycle later.
//  6 Assert rst mid-GRANT -> strobes, ack, busy drop asynchronously; after release, a CPU read completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RECOVER = 2'd2
  } arb_state_e;

  localparam logic       PORT_CPU  = 1'b0;
  localparam logic       PORT_DBG  = 1'b1;
  localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way picker: round-robin against last winner, or fixed port-0 priority.
module arb_rr2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       gnt
);

  // A single requester always wins; a tie goes to port 0 or to the port that did not win last.
  always_comb begin
    gnt = PORT_CPU;
    if (req == 2'b11) begin
      gnt = fixed ? PORT_CPU : ~last;
    end else if (req[1]) begin
      gnt = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the single-outstanding mem_ctrl bus, with recovery wait and watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  input  logic        dbg_read,
  input  logic        dbg_write,
  output logic [7:0]  dbg_rdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_tx,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [7:0]  bus_data_rx,
  input  logic        bus_wait,
  output logic        grant_id,
  output logic        busy
);

  // Counter value on the last allowed GRANT cycle; abort happens at that edge.
  localparam logic [CNT_W-1:0] WD_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] wd_q;
  logic             last_grant_q;

  logic [1:0]  req;
  logic        gnt;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic        sel_read;
  logic        sel_write;
  logic        wd_expired;
  logic        done;

  assign req        = {dbg_read | dbg_write, cpu_read | cpu_write};
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
  // Completion wins over a simultaneous watchdog expiry.
  assign done       = !bus_wait || wd_expired;

  arb_rr2 u_pick (
    .req   (req),
    .last  (last_grant_q),
    .fixed (FIXED_PRIO),
    .gnt   (gnt)
  );

  // Mux the winning requester's fields toward the bus latch.
  always_comb begin
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    sel_read  = cpu_read;
    sel_write = cpu_write;
    if (gnt == PORT_DBG) begin
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
      sel_read  = dbg_read;
      sel_write = dbg_write;
    end
  end

  // Arbitration FSM with registered bus strobes, acks, read data and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      wd_q         <= '0;
      last_grant_q <= PORT_DBG;
      bus_address  <= '0;
      bus_data_tx  <= '0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
      grant_id     <= PORT_CPU;
      busy         <= 1'b0;
      cpu_rdata    <= '0;
      cpu_ack      <= 1'b0;
      cpu_err      <= 1'b0;
      dbg_rdata    <= '0;
      dbg_ack      <= 1'b0;
      dbg_err      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      dbg_ack <= 1'b0;
      dbg_err <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          wd_q <= '0;
          if (|req) begin
            bus_address  <= sel_addr;
            bus_data_tx  <= sel_wdata;
            bus_write    <= sel_write;
            // Read and write together is a write.
            bus_read     <= sel_read & ~sel_write;
            grant_id     <= gnt;
            last_grant_q <= gnt;
            busy         <= 1'b1;
            state_q      <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (done) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            wd_q      <= '0;
            state_q   <= ARB_RECOVER;
            // bus_wait still high here means the watchdog fired.
            if (grant_id == PORT_DBG) begin
              dbg_ack   <= 1'b1;
              dbg_err   <= bus_wait;
              dbg_rdata <= bus_wait ? ERR_RDATA : bus_data_rx;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_err   <= bus_wait;
              cpu_rdata <= bus_wait ? ERR_RDATA : bus_data_rx;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ARB_RECOVER: begin
          wd_q <= '0;
          if (bus_wait) begin
            busy    <= 1'b0;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
